// File: rtl/controlador_ram_resposta_if.sv
// Request/response bus between the L1 cache's RAM-side port and the memory responder.
// The master is the cache side; the slave is the memory responder.
interface controlador_ram_resposta_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_write;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              busy;
  logic [15:0]       stat_reads;
  logic [15:0]       stat_writes;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_write, resp_rdata, resp_err,
           busy, stat_reads, stat_writes
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_write, resp_rdata, resp_err,
           busy, stat_reads, stat_writes
  );
endinterface

// File: rtl/controlador_ram_resposta.sv
// Memory-side responder for cache fills and writebacks: one request in flight,
// fixed access latency, internal directly-indexed RAM and saturating traffic counters.
module controlador_ram_resposta #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  controlador_ram_resposta_if.slave  bus
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              reqReady_q;
  logic              respValid_q;
  logic              respWrite_q;
  logic [DATA_W-1:0] respRdata_q;
  logic              respErr_q;
  logic              busy_q;
  logic [15:0]       statReads_q;
  logic [15:0]       statWrites_q;
  logic [15:0]       statReads_d;
  logic [15:0]       statWrites_d;

  // RAM is deliberately outside the reset domain; contents survive reset.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic              inRange;
  logic [IDX_W-1:0]  idx;
  logic              commit;
  logic [DATA_W-1:0] memRd;

  assign inRange = ({1'b0, addr_q} < DEPTH_A);
  assign idx     = addr_q[IDX_W-1:0];
  assign commit  = (state_q == ACCESS) && (cnt_q == '0);
  assign memRd   = inRange ? mem[idx] : '0;

  assign statReads_d  = (statReads_q  == 16'hFFFF) ? statReads_q  : statReads_q  + 16'd1;
  assign statWrites_d = (statWrites_q == 16'hFFFF) ? statWrites_q : statWrites_q + 16'd1;

  always_ff @(posedge clock) begin
    if (commit && write_q && inRange) begin
      mem[idx] <= wdata_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      reqReady_q   <= 1'b1;
      respValid_q  <= 1'b0;
      respWrite_q  <= 1'b0;
      respRdata_q  <= '0;
      respErr_q    <= 1'b0;
      busy_q       <= 1'b0;
      statReads_q  <= '0;
      statWrites_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            write_q    <= bus.req_write;
            addr_q     <= bus.req_addr;
            wdata_q    <= bus.req_wdata;
            cnt_q      <= CNT_LOAD;
            reqReady_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            respValid_q <= 1'b1;
            respWrite_q <= write_q;
            respRdata_q <= write_q ? '0 : memRd;
            respErr_q   <= !inRange;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          // A request waiting here is only taken after we are back in IDLE.
          if (bus.resp_ready) begin
            respValid_q <= 1'b0;
            reqReady_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
            if (!respErr_q) begin
              if (respWrite_q) begin
                statWrites_q <= statWrites_d;
              end else begin
                statReads_q <= statReads_d;
              end
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          reqReady_q  <= 1'b1;
          respValid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready   = reqReady_q;
  assign bus.resp_valid  = respValid_q;
  assign bus.resp_write  = respWrite_q;
  assign bus.resp_rdata  = respRdata_q;
  assign bus.resp_err    = respErr_q;
  assign bus.busy        = busy_q;
  assign bus.stat_reads  = statReads_q;
  assign bus.stat_writes = statWrites_q;

endmodule

// File: tb/tb_controlador_ram_resposta.sv
// Directed bench for controlador_ram_resposta: loads, stores, range errors,
// response back-pressure, mid-access reset and counter saturation.
module tb_controlador_ram_resposta;

  logic clock;
  logic reset_n;
  int   checkCount;
  int   errorCount;

  logic       gotWrite;
  logic [7:0] gotRdata;
  logic       gotErr;
  int         gotLatency;
  int         gotReadyLow;

  controlador_ram_resposta_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  controlador_ram_resposta #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(4), .LATENCY(2)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Presents a request at a negedge and holds it until the edge that accepts it.
  task automatic sendRequest(input logic write, input logic [7:0] addr, input logic [7:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_write = write;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  // Waits (bounded) for resp_valid, captures the response, then completes the handshake.
  task automatic waitResponse();
    int cycles;
    cycles      = 0;
    gotReadyLow = 0;
    while (!bus.resp_valid && cycles < 20) begin
      if (!bus.req_ready) gotReadyLow++;
      cycles++;
      @(negedge clock);
    end
    if (!bus.resp_valid) begin
      checkOutput("resp_timeout", {31'd0, bus.resp_valid}, 32'd1);
      return;
    end
    if (!bus.req_ready) gotReadyLow++;
    gotLatency = cycles;
    gotWrite   = bus.resp_write;
    gotRdata   = bus.resp_rdata;
    gotErr     = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.resp_ready = 1'b0;
  endtask

  task automatic applyStimulus(input logic write, input logic [7:0] addr, input logic [7:0] wdata);
    sendRequest(write, addr, wdata);
    waitResponse();
  endtask

  initial begin
    logic       stableOk;
    logic [7:0] heldRdata;
    checkCount     = 0;
    errorCount     = 0;
    reset_n        = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
    checkOutput("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    checkOutput("rst_busy",       {31'd0, bus.busy},       32'd0);
    checkOutput("rst_resp_rdata", {24'd0, bus.resp_rdata}, 32'd0);
    checkOutput("rst_stat_reads", {16'd0, bus.stat_reads}, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Plain load from untouched RAM
    applyStimulus(1'b0, 8'd2, 8'h00);
    checkOutput("t1_latency",    gotLatency,            32'd2);
    checkOutput("t1_ready_low",  gotReadyLow,           32'd3);
    checkOutput("t1_rdata",      {24'd0, gotRdata},     32'h00);
    checkOutput("t1_err",        {31'd0, gotErr},       32'd0);
    checkOutput("t1_stat_reads", {16'd0, bus.stat_reads}, 32'd1);
    checkOutput("t1_idle_ready", {31'd0, bus.req_ready},  32'd1);

    // Store then read back
    applyStimulus(1'b1, 8'd3, 8'hA5);
    checkOutput("t2_st_write",  {31'd0, gotWrite},   32'd1);
    checkOutput("t2_st_rdata",  {24'd0, gotRdata},   32'h00);
    applyStimulus(1'b0, 8'd3, 8'h00);
    checkOutput("t2_ld_write",  {31'd0, gotWrite},   32'd0);
    checkOutput("t2_ld_rdata",  {24'd0, gotRdata},   32'hA5);
    checkOutput("t2_stat_writes", {16'd0, bus.stat_writes}, 32'd1);
    checkOutput("t2_stat_reads",  {16'd0, bus.stat_reads},  32'd2);

    // Out-of-range address
    applyStimulus(1'b0, 8'h04, 8'h00);
    checkOutput("t3_err",        {31'd0, gotErr},     32'd1);
    checkOutput("t3_rdata",      {24'd0, gotRdata},   32'h00);
    checkOutput("t3_stat_reads", {16'd0, bus.stat_reads},  32'd2);
    checkOutput("t3_stat_writes",{16'd0, bus.stat_writes}, 32'd1);
    applyStimulus(1'b0, 8'd0, 8'h00);
    checkOutput("t3_addr0",      {24'd0, gotRdata},   32'h00);
    checkOutput("t3_addr0_err",  {31'd0, gotErr},     32'd0);

    // Back-pressure in RESP with a competing request held
    sendRequest(1'b0, 8'd3, 8'h00);
    repeat (2) @(negedge clock);
    checkOutput("t4_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    heldRdata     = bus.resp_rdata;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'd0;
    stableOk      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (!bus.resp_valid || bus.req_ready || bus.resp_rdata != heldRdata ||
          bus.resp_err || bus.resp_write) stableOk = 1'b0;
    end
    checkOutput("t4_held_rdata", {24'd0, heldRdata}, 32'hA5);
    checkOutput("t4_stable",     {31'd0, stableOk},  32'd1);
    bus.resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.resp_ready = 1'b0;
    checkOutput("t4_no_accept_busy", {31'd0, bus.busy},       32'd0);
    checkOutput("t4_idle_ready",     {31'd0, bus.req_ready},  32'd1);
    checkOutput("t4_resp_cleared",   {31'd0, bus.resp_valid}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    checkOutput("t4_accept_busy", {31'd0, bus.busy}, 32'd1);
    waitResponse();
    checkOutput("t4_second_rdata", {24'd0, gotRdata}, 32'h00);
    checkOutput("t4_stat_reads",   {16'd0, bus.stat_reads}, 32'd5);

    // Reset during ACCESS before the store commits
    sendRequest(1'b1, 8'd1, 8'h3C);
    reset_n = 1'b0;
    #1;
    checkOutput("t5_req_ready",   {31'd0, bus.req_ready},   32'd1);
    checkOutput("t5_busy",        {31'd0, bus.busy},        32'd0);
    checkOutput("t5_resp_valid",  {31'd0, bus.resp_valid},  32'd0);
    checkOutput("t5_stat_reads",  {16'd0, bus.stat_reads},  32'd0);
    checkOutput("t5_stat_writes", {16'd0, bus.stat_writes}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("t5_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    applyStimulus(1'b0, 8'd1, 8'h00);
    checkOutput("t5_old_value", {24'd0, gotRdata}, 32'h00);

    // Store counter saturation from a preloaded value
    force dut.statWrites_q = 16'hFFFE;
    #1;
    release dut.statWrites_q;
    @(negedge clock);
    applyStimulus(1'b1, 8'd0, 8'h11);
    checkOutput("t6_reach_max", {16'd0, bus.stat_writes}, 32'hFFFF);
    applyStimulus(1'b1, 8'd0, 8'h22);
    checkOutput("t6_saturated", {16'd0, bus.stat_writes}, 32'hFFFF);
    applyStimulus(1'b0, 8'd0, 8'h00);
    checkOutput("t6_rdata", {24'd0, gotRdata}, 32'h22);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
